// File: rtl/counter_sched.sv
// Programmable up/down timer/scheduler with a valid/ready config port and a terminal-count tick.
// Latency: count is visible one edge after start; one-shot tick/done arrive P+1 edges after start.
// Backpressure: cfg_ready is low while counting (RUN/PAUSE); config offers there are not taken.
// Optional feature macro: COUNTER_SCHED_PRESCALE_EN adds cfg_prescale, so a step occurs every cfg_prescale+1 cycles.
module counter_sched #(
    parameter int N  = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_period,
    input  logic          cfg_dir,
    input  logic          cfg_mode,
`ifdef COUNTER_SCHED_PRESCALE_EN
    input  logic [PW-1:0] cfg_prescale,
`endif
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    output logic [N-1:0]  count,
    output logic          busy,
    output logic          tick,
    output logic          done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [N-1:0] CNT_ZERO = '0;
    localparam logic [N-1:0] CNT_ONE  = N'(1);

    // Degenerate widths make no sense for either the counter or the prescaler.
    if (N < 1 || PW < 1) begin : g_param_chk
        $error("counter_sched: N and PW must both be at least 1");
    end

    logic [1:0]   state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;
    logic [N-1:0] per_q, per_d;
    logic         dir_q, dir_d;
    logic         mode_q, mode_d;

    logic cfg_acc;
    logic counting;
    logic start_ok;
    logic step_hit;
    logic at_term;

    // The config port is only open while no count is in progress.
    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign counting  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign start_ok  = !stop && start && cfg_ready;

`ifdef COUNTER_SCHED_PRESCALE_EN
    logic [PW-1:0] pre_q, pre_d;
    logic [PW-1:0] psc_q, psc_d;

    // Prescaler: divides the RUN cycles into steps; frozen while pause is held.
    always_comb begin
        pre_d    = cfg_acc ? cfg_prescale : pre_q;
        psc_d    = psc_q;
        step_hit = 1'b0;
        if (stop || start_ok) begin
            psc_d = '0;
        end else if (counting && !pause) begin
            if (psc_q == pre_q) begin
                psc_d    = '0;
                step_hit = 1'b1;
            end else begin
                psc_d = psc_q + PW'(1);
            end
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            psc_q <= '0;
        end else begin
            pre_q <= pre_d;
            psc_q <= psc_d;
        end
    end
`else
    // Without a prescaler every unpaused RUN cycle is a step.
    assign step_hit = counting && !pause;
`endif

    // Terminal value depends on direction: P when counting up, 0 when counting down.
    assign at_term = dir_q ? (count_q == CNT_ZERO) : (count_q == per_q);

    // Main sequencer: stop > start > pause > step.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        done_d  = done_q;
        per_d   = cfg_acc ? cfg_period : per_q;
        dir_d   = cfg_acc ? cfg_dir    : dir_q;
        mode_d  = cfg_acc ? cfg_mode   : mode_q;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
            done_d  = 1'b0;
        end else if (start_ok) begin
            // A config taken on this same edge is already visible through *_d.
            state_d = ST_RUN;
            count_d = dir_d ? per_d : CNT_ZERO;
            done_d  = 1'b0;
        end else if (counting) begin
            if (pause) begin
                state_d = ST_PAUSE;
            end else begin
                // Leaving PAUSE steps on the same edge, so a pause held for k edges
                // delays the schedule by exactly k edges.
                state_d = ST_RUN;
                if (step_hit) begin
                    if (at_term) begin
                        tick_d = 1'b1;
                        if (mode_q) begin
                            count_d = dir_q ? per_q : CNT_ZERO;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = dir_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
                    end
                end
            end
        end
    end

    // State, count, outputs and shadow config registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            per_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign count = count_q;
    assign busy  = counting;
    assign tick  = tick_q;
    assign done  = done_q;

endmodule
